// File: rtl/clock_pkg.sv
// Shared types and field limits for the BCD time keeper.
package clock_pkg;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2
  } field_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_LO  = 1;
  localparam int HR12_HI  = 12;

  // Two-digit binary to {tens, ones} BCD; used for elaboration constants.
  function automatic logic [7:0] to_bcd2(input int v);
    bcd_t t, o;
    t = bcd_t'(v / 10);
    o = bcd_t'(v % 10);
    return {t, o};
  endfunction
endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter wrapping between LO and HI; holds legal BCD only.
module bcd_pair_counter import clock_pkg::*; #(
  parameter int LO  = 0,
  parameter int HI  = 59,
  parameter int RST = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load_lo,
  input  logic load_hi,
  output bcd_t tens,
  output bcd_t ones,
  output logic at_hi,
  output logic at_lo
);
  localparam logic [7:0] LO_B  = to_bcd2(LO);
  localparam logic [7:0] HI_B  = to_bcd2(HI);
  localparam logic [7:0] RST_B = to_bcd2(RST);

  assign at_hi = ({tens, ones} == HI_B);
  assign at_lo = ({tens, ones} == LO_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       {tens, ones} <= RST_B;
    else if (load_lo) {tens, ones} <= LO_B;
    else if (load_hi) {tens, ones} <= HI_B;
    else if (inc) begin
      if (at_hi)              {tens, ones} <= LO_B;
      else if (ones == 4'd9) begin tens <= tens + 4'd1; ones <= 4'd0; end
      else                    ones <= ones + 4'd1;
    end else if (dec) begin
      if (at_lo)              {tens, ones} <= HI_B;
      else if (ones == 4'd0) begin tens <= tens - 4'd1; ones <= 4'd9; end
      else                    ones <= ones - 4'd1;
    end
  end
endmodule

// File: rtl/bcd_time_keeper.sv
// HH:MM:SS BCD clock with 1 Hz advance, button-driven field editing and 12/24 h display.
module bcd_time_keeper import clock_pkg::*; #(
  parameter bit TWELVE_HR = 1'b0,
  parameter int RST_HOUR  = 13,
  parameter int RST_MIN   = 45,
  parameter int RST_SEC   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clr,
  input  logic       edit_en,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic [3:0] h1,
  output logic [3:0] h2,
  output logic       pm,
  output logic [1:0] pos,
  output logic [2:0] pos_led,
  output logic       day_tick
);
  localparam int HR_LO  = TWELVE_HR ? HR12_LO : 0;
  localparam int HR_HI  = TWELVE_HR ? HR12_HI : HR24_MAX;
  localparam int HR_RST = TWELVE_HR ? ((RST_HOUR % 12 == 0) ? 12 : RST_HOUR % 12) : RST_HOUR;
  localparam bit PM_RST = TWELVE_HR && (RST_HOUR >= 12);

  field_e pos_q, pos_d;
  logic do_edit, do_tick, b_l, b_r, b_u, b_d;
  logic sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic sec_hi, min_hi, hr_hi, hr_is11, carry, day_wrap, pm_d;

  // One action per cycle: clr beats edit beats tick; buttons L > R > U > D.
  assign do_edit = !clr && edit_en;
  assign do_tick = !clr && !edit_en && tick;
  assign b_l = do_edit && btn_l;
  assign b_r = do_edit && !btn_l && btn_r;
  assign b_u = do_edit && !btn_l && !btn_r && btn_u;
  assign b_d = do_edit && !btn_l && !btn_r && !btn_u && btn_d;

  assign carry   = do_tick && sec_hi && min_hi;
  assign sec_inc = do_tick || (b_u && pos_q == FLD_SEC);
  assign sec_dec = b_d && pos_q == FLD_SEC;
  assign min_inc = (do_tick && sec_hi) || (b_u && pos_q == FLD_MIN);
  assign min_dec = b_d && pos_q == FLD_MIN;
  assign hr_inc  = carry || (b_u && pos_q == FLD_HOUR);
  assign hr_dec  = b_d && pos_q == FLD_HOUR;
  assign hr_is11 = (h2 == 4'd1) && (h1 == 4'd1);

  bcd_pair_counter #(.LO(0), .HI(SEC_MAX), .RST(RST_SEC)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(sec_inc), .dec(sec_dec), .load_lo(clr), .load_hi(1'b0),
    .tens(s2), .ones(s1), .at_hi(sec_hi), .at_lo());
  bcd_pair_counter #(.LO(0), .HI(MIN_MAX), .RST(RST_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .dec(min_dec), .load_lo(clr), .load_hi(1'b0),
    .tens(m2), .ones(m1), .at_hi(min_hi), .at_lo());
  // Midnight in 12 h mode is 12 AM, i.e. the hour counter's HI value.
  bcd_pair_counter #(.LO(HR_LO), .HI(HR_HI), .RST(HR_RST)) u_hour (
    .clk(clk), .rst_n(rst_n), .inc(hr_inc), .dec(hr_dec),
    .load_lo(clr && !TWELVE_HR), .load_hi(clr && TWELVE_HR),
    .tens(h2), .ones(h1), .at_hi(hr_hi), .at_lo());

  always_comb begin
    pm_d     = 1'b0;
    day_wrap = 1'b0;
    if (TWELVE_HR) begin
      day_wrap = carry && hr_is11 && pm;
      if (clr)                                       pm_d = 1'b0;
      else if ((hr_inc && hr_is11) || (hr_dec && hr_hi)) pm_d = !pm;
      else                                           pm_d = pm;
    end else begin
      day_wrap = carry && hr_hi;
    end
  end

  always_comb begin
    pos_d = pos_q;
    if (b_l) begin
      case (pos_q)
        FLD_SEC: pos_d = FLD_MIN;
        FLD_MIN: pos_d = FLD_HOUR;
        default: pos_d = FLD_SEC;
      endcase
    end else if (b_r) begin
      case (pos_q)
        FLD_HOUR: pos_d = FLD_MIN;
        FLD_MIN:  pos_d = FLD_SEC;
        default:  pos_d = FLD_HOUR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= FLD_SEC;
      pm       <= PM_RST;
      day_tick <= 1'b0;
      pos_led  <= 3'b000;
    end else begin
      pos_q    <= pos_d;
      pm       <= pm_d;
      day_tick <= day_wrap;
      pos_led  <= edit_en ? (3'b001 << pos_d) : 3'b000;
    end
  end

  assign pos = pos_q;
endmodule
